seg7_reader: RTL

Bus-side reader for the board's six active-low 7-segment display buses. It samples the HEX0–HEX5 drive patterns and waits until they are stable. It then decodes each pattern back to its 4-bit hex value, plus decimal-point and blank flags, and returns the result through a valid/ready handshake. It sits beside the display decoders as an on-chip self-check: display contents can be read back and compared against the nibbles that produced them.

---
 rtl/seg7_reader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// Reads back six active-low 7-segment buses, waits for stable patterns and decodes them to nibbles.
// Optional invalid-glyph counter enabled by defining SEG7_READER_ERRCNT_EN.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  HEX0,
  input  logic [7:0]  HEX1,
  input  logic [7:0]  HEX2,
  input  logic [7:0]  HEX3,
  input  logic [7:0]  HEX4,
  input  logic [7:0]  HEX5,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] value,
  output logic [5:0]  digit_ok,
  output logic [5:0]  dp,
  output logic [5:0]  blank,
  output logic        timeout,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0]  StabLast = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StScan, StDone} state_e;

  state_e      state_q;
  logic [47:0] snap_q;
  logic [7:0]  stab_q;
  logic [15:0] tmo_q;
  logic [2:0]  idx_q;
  logic [23:0] value_q;
  logic [5:0]  ok_q, dp_q, blank_q;
  logic        timeout_q;

  logic [47:0] hex_in;
  logic        in_match;
  logic [7:0]  cur;
  logic [4:0]  dec;
  logic        cur_blank;
  logic [23:0] value_d;
  logic [5:0]  ok_d, dp_d, blank_d;

  assign hex_in   = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign in_match = (hex_in == snap_q);

  // Returns {legal, nibble}; bit7 (dp) is handled separately.
  function automatic logic [4:0] glyph(input logic [6:0] seg);
    case (seg)
      7'h40:   glyph = 5'h10;
      7'h79:   glyph = 5'h11;
      7'h24:   glyph = 5'h12;
      7'h30:   glyph = 5'h13;
      7'h19:   glyph = 5'h14;
      7'h12:   glyph = 5'h15;
      7'h02:   glyph = 5'h16;
      7'h78:   glyph = 5'h17;
      7'h00:   glyph = 5'h18;
      7'h10:   glyph = 5'h19;
      7'h08:   glyph = 5'h1A;
      7'h03:   glyph = 5'h1B;
      7'h46:   glyph = 5'h1C;
      7'h21:   glyph = 5'h1D;
      7'h06:   glyph = 5'h1E;
      7'h0E:   glyph = 5'h1F;
      default: glyph = 5'h00;
    endcase
  endfunction

  always_comb begin
    cur = 8'hFF;
    case (idx_q)
      3'd0:    cur = snap_q[7:0];
      3'd1:    cur = snap_q[15:8];
      3'd2:    cur = snap_q[23:16];
      3'd3:    cur = snap_q[31:24];
      3'd4:    cur = snap_q[39:32];
      3'd5:    cur = snap_q[47:40];
      default: cur = 8'hFF;
    endcase
  end

  assign dec       = glyph(cur[6:0]);
  assign cur_blank = (cur[6:0] == 7'h7F);

  always_comb begin
    value_d = value_q;
    ok_d    = ok_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    for (int i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) begin
        value_d[4*i +: 4] = dec[4] ? dec[3:0] : 4'h0;
        ok_d[i]           = dec[4];
        dp_d[i]           = ~cur[7];
        blank_d[i]        = cur_blank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      snap_q    <= '0;
      stab_q    <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
      value_q   <= '0;
      ok_q      <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            snap_q    <= hex_in;
            stab_q    <= '0;
            tmo_q     <= '0;
            idx_q     <= '0;
            value_q   <= '0;
            ok_q      <= '0;
            dp_q      <= '0;
            blank_q   <= '0;
            timeout_q <= 1'b0;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          tmo_q <= tmo_q + 16'd1;
          if (in_match) begin
            stab_q <= stab_q + 8'd1;
          end else begin
            snap_q <= hex_in;
            stab_q <= '0;
          end
          // Stability takes priority over an expiring timeout in the same cycle.
          if (in_match && stab_q == StabLast) begin
            idx_q   <= '0;
            state_q <= StScan;
          end else if (tmo_q == TmoLast) begin
            timeout_q <= 1'b1;
            state_q   <= StDone;
          end
        end
        StScan: begin
          value_q <= value_d;
          ok_q    <= ok_d;
          dp_q    <= dp_d;
          blank_q <= blank_d;
          idx_q   <= idx_q + 3'd1;
          if (idx_q == 3'd5) state_q <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign value     = value_q;
  assign digit_ok  = ok_q;
  assign dp        = dp_q;
  assign blank     = blank_q;
  assign timeout   = timeout_q;

`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (state_q == StScan && !dec[4] && !cur_blank && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h0;
`endif

endmodule
